// File: rtl/bf_stage_seq_if.sv
// Control bundle between a butterfly-stage sequencer and whatever starts
// frames and consumes its select/enable/index/status outputs.
interface bf_stage_seq_if #(
  parameter int CNT_W = 6
);
  logic             valid_in;
  logic             soft_clr;
  logic             sel_in;
  logic             mux_en;
  logic [CNT_W-1:0] tw_idx;
  logic             busy;
  logic             frame_done;
  logic             start_err;

  // Frame source / status consumer side
  modport master (
    output valid_in, soft_clr,
    input  sel_in, mux_en, tw_idx, busy, frame_done, start_err
  );

  // Sequencer side
  modport slave (
    input  valid_in, soft_clr,
    output sel_in, mux_en, tw_idx, busy, frame_done, start_err
  );
endinterface

// File: rtl/bf_stage_seq.sv
// Control sequencer for one parallel radix-2 butterfly stage.
// An input-side FSM counts the beats of a frame and drives the demux select;
// an output-side FSM, kicked by the input side at beat DEPTH-1, drives the
// twiddle mux enable and index. The two sides overlap so back-to-back frames
// run without a bubble. Every output is a flop.
module bf_stage_seq #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic           clk,
  input  logic           rstn,
  bf_stage_seq_if.slave  bus
);

  typedef enum logic { IN_IDLE  = 1'b0, IN_RUN  = 1'b1 } in_state_t;
  typedef enum logic { OUT_IDLE = 1'b0, OUT_RUN = 1'b1 } out_state_t;

  // Bit of the beat counter that toggles every DEPTH beats
  localparam int               SEL_BIT  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(DEPTH - 1);

  in_state_t        in_state_q,  in_state_d;
  out_state_t       out_state_q, out_state_d;
  logic [CNT_W-1:0] in_cnt_q,    in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;

  logic             sel_in_q,     sel_in_d;
  logic             mux_en_q,     mux_en_d;
  logic [CNT_W-1:0] tw_idx_q,     tw_idx_d;
  logic             busy_q,       busy_d;
  logic             frame_done_q, frame_done_d;
  logic             start_err_q,  start_err_d;

  logic             out_trig;

  // Input side: accept starts, count beats, flag strobes that land mid-frame
  always_comb begin
    in_state_d  = in_state_q;
    in_cnt_d    = in_cnt_q;
    start_err_d = 1'b0;
    if (bus.soft_clr) begin
      in_state_d = IN_IDLE;
      in_cnt_d   = '0;
    end else begin
      unique case (in_state_q)
        IN_IDLE: begin
          if (bus.valid_in) begin
            in_state_d = IN_RUN;
            in_cnt_d   = '0;
          end
        end
        IN_RUN: begin
          if (in_cnt_q == CNT_LAST) begin
            // A strobe right after the last beat is a back-to-back start
            in_state_d = bus.valid_in ? IN_RUN : IN_IDLE;
            in_cnt_d   = '0;
          end else begin
            in_cnt_d    = in_cnt_q + 1'b1;
            start_err_d = bus.valid_in;
          end
        end
        default: begin
          in_state_d = IN_IDLE;
          in_cnt_d   = '0;
        end
      endcase
    end
  end

  // Output side is launched once the delay line holds DEPTH beats
  assign out_trig = (in_state_q == IN_RUN) && (in_cnt_q == CNT_TRIG);

  // Output side: run FRAME_LEN enable beats, pulse done after the last one
  always_comb begin
    out_state_d  = out_state_q;
    out_cnt_d    = out_cnt_q;
    frame_done_d = 1'b0;
    if (bus.soft_clr) begin
      out_state_d = OUT_IDLE;
      out_cnt_d   = '0;
    end else begin
      if (out_state_q == OUT_RUN) begin
        if (out_cnt_q == CNT_LAST) begin
          out_state_d  = OUT_IDLE;
          out_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      // A new frame's launch coincides with the previous frame's last beat
      // at most, so restarting here never truncates a running drain.
      if (out_trig) begin
        out_state_d = OUT_RUN;
        out_cnt_d   = '0;
      end
    end
  end

  // Output decode from next state so the registered outputs line up with beats
  always_comb begin
    sel_in_d = (in_state_d == IN_RUN) && in_cnt_d[SEL_BIT];
    mux_en_d = (out_state_d == OUT_RUN);
    tw_idx_d = (out_state_d == OUT_RUN) ? out_cnt_d : '0;
    busy_d   = (in_state_d == IN_RUN) || (out_state_d == OUT_RUN);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_state_q   <= IN_IDLE;
      out_state_q  <= OUT_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      sel_in_q     <= 1'b0;
      mux_en_q     <= 1'b0;
      tw_idx_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      sel_in_q     <= sel_in_d;
      mux_en_q     <= mux_en_d;
      tw_idx_q     <= tw_idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign bus.sel_in     = sel_in_q;
  assign bus.mux_en     = mux_en_q;
  assign bus.tw_idx     = tw_idx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.start_err  = start_err_q;

endmodule

// File: tb/tb_bf_stage_seq.sv
// Bench for bf_stage_seq (DEPTH=4, FRAME_LEN=32, CNT_W=6).
// Cycle r counts clock edges since reset release; a start "at r" means the
// strobe is sampled at edge r so beat 0 is visible during cycle r. soft_clr
// and illegal strobes are held during cycle r and sampled at edge r+1.
module tb_bf_stage_seq;

  typedef struct packed {
    logic       sel;
    logic       mux;
    logic [5:0] tw;
    logic       busy;
    logic       done;
    logic       err;
  } outs_t;

  typedef struct {
    int    scn;
    int    r;
    outs_t exp;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  bf_stage_seq_if #(.CNT_W(6)) bus ();

  bf_stage_seq #(.DEPTH(4), .FRAME_LEN(32), .CNT_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(logic s, logic m, int t, logic b, logic d, logic e);
    outs_t o;
    o.sel = s; o.mux = m; o.tw = 6'(t); o.busy = b; o.done = d; o.err = e;
    return o;
  endfunction

  // Nominal outputs of a lone frame whose beat 0 is cycle base
  function automatic outs_t single(int base, int r);
    outs_t o;
    int    b;
    o = '0;
    b = r - base;
    if (b >= 0 && b < 32) o.sel = (((b / 4) % 2) == 1);
    if (b >= 4 && b < 36) begin
      o.mux = 1'b1;
      o.tw  = 6'(b - 4);
    end
    o.done = (b == 36);
    o.busy = (b >= 0 && b < 36);
    return o;
  endfunction

  function automatic outs_t expected(int scn, int r);
    outs_t o;
    case (scn)
      0: o = single(10, r);
      1: o = single(10, r) | single(42, r);
      2: begin o = single(10, r); o.err = (r == 21); end
      3: o = single(10, r) | single(43, r);
      4: o = (r < 26) ? single(10, r) : single(30, r);
      default: o = (r <= 20) ? single(10, r) : single(30, r);
    endcase
    return o;
  endfunction

  function automatic outs_t sample();
    return mk(bus.sel_in, bus.mux_en, int'(bus.tw_idx), bus.busy, bus.frame_done, bus.start_err);
  endfunction

  task automatic chk(input string name, input int scn, input int r, input outs_t act, input outs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s scn=%0d r=%0d got sel=%b mux=%b tw=%0d busy=%b done=%b err=%b want sel=%b mux=%b tw=%0d busy=%b done=%b err=%b",
               name, scn, r, act.sel, act.mux, act.tw, act.busy, act.done, act.err,
               exp.sel, exp.mux, exp.tw, exp.busy, exp.done, exp.err);
    end
  endtask

  vec_t tbl [15];

  initial begin
    // Hand-computed spot values
    tbl[0]  = '{0, 10, mk(0, 0,  0, 1, 0, 0)};
    tbl[1]  = '{0, 13, mk(0, 0,  0, 1, 0, 0)};
    tbl[2]  = '{0, 14, mk(1, 1,  0, 1, 0, 0)};
    tbl[3]  = '{0, 18, mk(0, 1,  4, 1, 0, 0)};
    tbl[4]  = '{0, 41, mk(1, 1, 27, 1, 0, 0)};
    tbl[5]  = '{0, 42, mk(0, 1, 28, 1, 0, 0)};
    tbl[6]  = '{0, 45, mk(0, 1, 31, 1, 0, 0)};
    tbl[7]  = '{0, 46, mk(0, 0,  0, 0, 1, 0)};
    tbl[8]  = '{0, 47, mk(0, 0,  0, 0, 0, 0)};
    tbl[9]  = '{1, 46, mk(1, 1,  0, 1, 1, 0)};
    tbl[10] = '{1, 78, mk(0, 0,  0, 0, 1, 0)};
    tbl[11] = '{2, 21, mk(0, 1,  7, 1, 0, 1)};
    tbl[12] = '{3, 46, mk(0, 0,  0, 1, 1, 0)};
    tbl[13] = '{4, 26, mk(0, 0,  0, 0, 0, 0)};
    tbl[14] = '{5, 20, mk(0, 1,  6, 1, 0, 0)};

    bus.valid_in = 1'b0;
    bus.soft_clr = 1'b0;

    for (int scn = 0; scn < 6; scn++) begin
      // Reset between scenarios
      @(negedge clk);
      rstn = 1'b0;
      bus.valid_in = 1'b0;
      bus.soft_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset", scn, -1, sample(), '0);
      rstn = 1'b1;

      for (int r = 0; r <= 90; r++) begin
        logic v;
        chk("cycle", scn, r, sample(), expected(scn, r));
        for (int i = 0; i < 15; i++)
          if (tbl[i].scn == scn && tbl[i].r == r)
            chk("vector", scn, r, sample(), tbl[i].exp);

        if (scn == 5 && r == 20) begin
          rstn = 1'b0;
          #1;
          chk("async_rst", scn, r, sample(), '0);
        end
        if (scn == 5 && r == 22) rstn = 1'b1;

        // Inputs for the next edge
        case (scn)
          0: v = (r + 1 == 10);
          1: v = (r + 1 == 10) || (r + 1 == 42);
          2: v = (r + 1 == 10) || (r + 1 == 21);
          3: v = (r + 1 == 10) || (r + 1 == 43);
          default: v = (r + 1 == 10) || (r + 1 == 30);
        endcase
        bus.valid_in = v;
        bus.soft_clr = (scn == 4) && (r + 1 == 26);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
